// File: rtl/classic_index_fetch.sv
// rtl/classic_index_fetch.sv - VGA-timed 2x upscaling map ROM fetch with per-frame highlight substitution
module classic_index_fetch #(
    parameter int IMG_W   = 320,
    parameter int IMG_H   = 240,
    parameter int ADDR_W  = 17,
    parameter int ROM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic              de_in,
    input  logic              hl_en,
    input  logic [4:0]        hl_src,
    input  logic [4:0]        hl_dst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [4:0]        rom_data,
    output logic [4:0]        index,
    output logic              hs_out,
    output logic              vs_out,
    output logic              de_out
);
    localparam int COL_W = $clog2(IMG_W + 1);
    localparam int ROW_W = $clog2(IMG_H + 1);
    localparam logic [COL_W-1:0]  COL_END   = COL_W'(IMG_W);
    localparam logic [ROW_W-1:0]  ROW_END   = ROW_W'(IMG_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic oob;
    } tap_t;

    localparam tap_t TAP_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0, oob: 1'b0};

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] line_base;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              x_half;
    logic              line_odd;
    logic              prev_de;
    logic              prev_vs;
    logic              hl_en_s;
    logic [4:0]        hl_src_s;
    logic [4:0]        hl_dst_s;
    tap_t              pipe [0:ROM_LAT];

    logic frame_start;
    logic line_end;
    logic in_img;

    assign frame_start = prev_vs & ~vs_in;
    assign line_end    = prev_de & ~de_in;
    assign in_img      = de_in && (col < COL_END) && (row < ROW_END);

    // Frame start has priority over a coincident line end so no stale rewind survives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr      <= '0;
            line_base <= '0;
            col       <= '0;
            row       <= '0;
            x_half    <= 1'b0;
            line_odd  <= 1'b0;
            prev_de   <= 1'b0;
            prev_vs   <= 1'b1;
            hl_en_s   <= 1'b0;
            hl_src_s  <= '0;
            hl_dst_s  <= '0;
            rom_addr  <= '0;
        end else begin
            prev_de <= de_in;
            prev_vs <= vs_in;
            if (frame_start) begin
                addr      <= '0;
                line_base <= '0;
                col       <= '0;
                row       <= '0;
                x_half    <= 1'b0;
                line_odd  <= 1'b0;
                hl_en_s   <= hl_en;
                hl_src_s  <= hl_src;
                hl_dst_s  <= hl_dst;
            end else if (line_end) begin
                x_half <= 1'b0;
                col    <= '0;
                if (!line_odd) begin
                    addr     <= line_base;
                    line_odd <= 1'b1;
                end else begin
                    line_base <= addr;
                    line_odd  <= 1'b0;
                    if (row != ROW_END) begin
                        row <= row + ROW_W'(1);
                    end
                end
            end else if (in_img) begin
                rom_addr <= addr;
                x_half   <= ~x_half;
                if (x_half) begin
                    col <= col + COL_W'(1);
                    if (addr != LAST_ADDR) begin
                        addr <= addr + ADDR_W'(1);
                    end
                end
            end
        end
    end

    // Flag taps: stage 0 lines up with rom_addr, stage ROM_LAT with rom_data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= ROM_LAT; i++) begin
                pipe[i] <= TAP_IDLE;
            end
        end else begin
            pipe[0] <= '{hs: hs_in, vs: vs_in, de: de_in, oob: de_in & ~in_img};
            for (int i = 1; i <= ROM_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            index  <= '0;
            hs_out <= 1'b1;
            vs_out <= 1'b1;
            de_out <= 1'b0;
        end else begin
            hs_out <= pipe[ROM_LAT].hs;
            vs_out <= pipe[ROM_LAT].vs;
            de_out <= pipe[ROM_LAT].de;
            if (!pipe[ROM_LAT].de || pipe[ROM_LAT].oob) begin
                index <= '0;
            end else if (hl_en_s && rom_data == hl_src_s) begin
                index <= hl_dst_s;
            end else begin
                index <= rom_data;
            end
        end
    end
endmodule

// File: tb/tb_classic_index_fetch.sv
// tb/tb_classic_index_fetch.sv - directed self-checking bench for classic_index_fetch
module tb_classic_index_fetch;
    localparam int HN = 32768;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        hs_in, vs_in, de_in;
    logic        hl_en;
    logic [4:0]  hl_src, hl_dst;
    logic [16:0] rom_addr;
    logic [4:0]  rom_data;
    logic [4:0]  index;
    logic        hs_out, vs_out, de_out;

    logic [16:0] rom_q1 = '0;
    logic [16:0] rom_q2 = '0;

    logic [16:0] h_addr  [0:HN-1];
    logic [4:0]  h_index [0:HN-1];
    logic        h_de [0:HN-1];
    logic        h_hs [0:HN-1];
    logic        h_vs [0:HN-1];
    logic        i_de [0:HN-1];
    logic        i_hs [0:HN-1];
    logic        i_vs [0:HN-1];

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;

    classic_index_fetch #(.IMG_W(320), .IMG_H(240), .ADDR_W(17), .ROM_LAT(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
        .hl_en(hl_en), .hl_src(hl_src), .hl_dst(hl_dst),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .index(index), .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out)
    );

    always #5 clk = ~clk;

    // Two-cycle ROM whose word is the low five address bits.
    always @(posedge clk) begin
        rom_q1 <= rom_addr;
        rom_q2 <= rom_q1;
    end
    assign rom_data = rom_q2[4:0];

    task automatic tick(input logic de, input logic hs, input logic vs);
        de_in = de;
        hs_in = hs;
        vs_in = vs;
        @(posedge clk);
        #1;
        if (cyc < HN) begin
            i_de[cyc] = de;  i_hs[cyc] = hs;  i_vs[cyc] = vs;
            h_addr[cyc] = rom_addr;  h_index[cyc] = index;
            h_de[cyc] = de_out;  h_hs[cyc] = hs_out;  h_vs[cyc] = vs_out;
        end
        cyc++;
    endtask

    task automatic vsync();
        repeat (4) tick(1'b0, 1'b1, 1'b1);
        repeat (4) tick(1'b0, 1'b0, 1'b0);
        repeat (4) tick(1'b0, 1'b1, 1'b1);
    endtask

    task automatic do_line(input int npix, output int s);
        s = cyc;
        repeat (npix) tick(1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        de_in = 1'b0; hs_in = 1'b1; vs_in = 1'b0;
        hl_en = 1'b0; hl_src = 5'd0; hl_dst = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (rom_addr !== 17'd0) $display("FAIL reset_rom_addr: got %0d expected 0", rom_addr); else n_pass++;
        n_total++; if (index !== 5'd0) $display("FAIL reset_index: got %0d expected 0", index); else n_pass++;
        n_total++; if (de_out !== 1'b0) $display("FAIL reset_de_out: got %b expected 0", de_out); else n_pass++;
        n_total++; if (hs_out !== 1'b1 || vs_out !== 1'b1) $display("FAIL reset_sync: got hs=%b vs=%b expected 1/1", hs_out, vs_out); else n_pass++;
        reset_n = 1'b1;
        repeat (3) tick(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_fetch();
        int s[4];
        int pl[8] = '{0, 1, 2, 3, 100, 101, 638, 639};
        logic [16:0] ea;
        vsync();
        for (int y = 0; y < 4; y++) do_line(640, s[y]);
        for (int y = 0; y < 4; y++) begin
            for (int k = 0; k < 8; k++) begin
                ea = 17'((y / 2) * 320 + pl[k] / 2);
                n_total++;
                if (h_addr[s[y] + pl[k]] !== ea)
                    $display("FAIL fetch_addr y=%0d p=%0d: got %0d expected %0d", y, pl[k], h_addr[s[y] + pl[k]], ea);
                else n_pass++;
                n_total++;
                if (h_index[s[y] + pl[k] + 3] !== ea[4:0])
                    $display("FAIL fetch_index y=%0d p=%0d: got %0d expected %0d", y, pl[k], h_index[s[y] + pl[k] + 3], ea[4:0]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_latency();
        int s, s1, f0, errs;
        f0 = cyc;
        vsync();
        do_line(640, s);
        do_line(640, s1);
        n_total++; if (h_de[s + 2] !== 1'b0) $display("FAIL lat_de_early: got %b expected 0", h_de[s + 2]); else n_pass++;
        n_total++; if (h_de[s + 3] !== 1'b1) $display("FAIL lat_de_rise: got %b expected 1", h_de[s + 3]); else n_pass++;
        n_total++; if (h_index[s + 3] !== 5'd0 || h_index[s + 5] !== 5'd1)
            $display("FAIL lat_first_index: got %0d,%0d expected 0,1", h_index[s + 3], h_index[s + 5]); else n_pass++;
        n_total++; if (h_de[s1 + 643] !== 1'b0) $display("FAIL lat_de_fall: got %b expected 0", h_de[s1 + 643]); else n_pass++;
        errs = 0;
        for (int j = f0; j < cyc - 3; j++)
            if (h_hs[j + 3] !== i_hs[j] || h_vs[j + 3] !== i_vs[j] || h_de[j + 3] !== i_de[j]) errs++;
        n_total++; if (errs != 0) $display("FAIL sync_align: got %0d misaligned cycles expected 0", errs); else n_pass++;
    endtask

    task automatic test_overscan();
        int s0, s1, s2, s3;
        vsync();
        do_line(700, s0);
        do_line(700, s1);
        do_line(640, s2);
        do_line(640, s3);
        n_total++; if (h_index[s0 + 639 + 3] !== 5'd31) $display("FAIL ovs_last_in: got %0d expected 31", h_index[s0 + 642]); else n_pass++;
        n_total++; if (h_index[s0 + 640 + 3] !== 5'd0 || h_index[s0 + 699 + 3] !== 5'd0)
            $display("FAIL ovs_index: got %0d,%0d expected 0,0", h_index[s0 + 643], h_index[s0 + 702]); else n_pass++;
        n_total++; if (h_de[s0 + 699 + 3] !== 1'b1) $display("FAIL ovs_de: got %b expected 1", h_de[s0 + 702]); else n_pass++;
        n_total++; if (h_addr[s0 + 699] !== 17'd319) $display("FAIL ovs_addr_hold: got %0d expected 319", h_addr[s0 + 699]); else n_pass++;
        n_total++; if (h_addr[s1] !== 17'd0 || h_addr[s1 + 699] !== 17'd319)
            $display("FAIL ovs_line1: got %0d,%0d expected 0,319", h_addr[s1], h_addr[s1 + 699]); else n_pass++;
        n_total++; if (h_addr[s2] !== 17'd320) $display("FAIL ovs_line2_base: got %0d expected 320", h_addr[s2]); else n_pass++;
        n_total++; if (h_index[s2 + 5] !== 5'd1) $display("FAIL ovs_line2_index: got %0d expected 1", h_index[s2 + 5]); else n_pass++;
        n_total++; if (h_addr[s3 + 639] !== 17'd639) $display("FAIL ovs_line3_end: got %0d expected 639", h_addr[s3 + 639]); else n_pass++;
    endtask

    task automatic test_highlight();
        int a0, a1, a2, b0, b1, b2;
        hl_en = 1'b0; hl_src = 5'd0; hl_dst = 5'd0;
        vsync();
        do_line(640, a0);
        hl_en = 1'b1; hl_src = 5'd5; hl_dst = 5'd11;
        do_line(640, a1);
        do_line(640, a2);
        n_total++; if (h_index[a1 + 13] !== 5'd5 || h_index[a2 + 13] !== 5'd5)
            $display("FAIL hl_midframe: got %0d,%0d expected 5,5", h_index[a1 + 13], h_index[a2 + 13]); else n_pass++;
        vsync();
        do_line(640, b0);
        hl_en = 1'b0; hl_dst = 5'd3;
        do_line(640, b1);
        do_line(640, b2);
        n_total++; if (h_index[b0 + 13] !== 5'd11 || h_index[b0 + 14] !== 5'd11)
            $display("FAIL hl_subst: got %0d,%0d expected 11,11", h_index[b0 + 13], h_index[b0 + 14]); else n_pass++;
        n_total++; if (h_index[b0 + 15] !== 5'd6 || h_index[b0 + 3] !== 5'd0)
            $display("FAIL hl_pass: got %0d,%0d expected 6,0", h_index[b0 + 15], h_index[b0 + 3]); else n_pass++;
        n_total++; if (h_index[b1 + 13] !== 5'd11) $display("FAIL hl_hold: got %0d expected 11", h_index[b1 + 13]); else n_pass++;
        n_total++; if (h_index[b2 + 13] !== 5'd11 || h_index[b2 + 77] !== 5'd11)
            $display("FAIL hl_row2: got %0d,%0d expected 11,11", h_index[b2 + 13], h_index[b2 + 77]); else n_pass++;
        n_total++; if (h_index[b2 + 15] !== 5'd6) $display("FAIL hl_row2_pass: got %0d expected 6", h_index[b2 + 15]); else n_pass++;
    endtask

    task automatic test_reset_midline();
        int s0, s1, s2;
        hl_en = 1'b1; hl_src = 5'd5; hl_dst = 5'd11;
        vsync();
        repeat (50) tick(1'b1, 1'b1, 1'b1);
        n_total++; if (index !== 5'd23 || de_out !== 1'b1)
            $display("FAIL rst_pre: got index=%0d de=%b expected 23/1", index, de_out); else n_pass++;
        #2;
        reset_n = 1'b0;
        #1;
        n_total++; if (index !== 5'd0 || de_out !== 1'b0)
            $display("FAIL rst_async_out: got index=%0d de=%b expected 0/0", index, de_out); else n_pass++;
        n_total++; if (hs_out !== 1'b1 || vs_out !== 1'b1 || rom_addr !== 17'd0)
            $display("FAIL rst_async_sync: got hs=%b vs=%b addr=%0d expected 1/1/0", hs_out, vs_out, rom_addr); else n_pass++;
        repeat (5) tick(1'b0, 1'b1, 1'b1);
        reset_n = 1'b1;
        hl_en = 1'b0;
        repeat (3) tick(1'b0, 1'b1, 1'b1);
        vsync();
        do_line(640, s0);
        do_line(640, s1);
        do_line(640, s2);
        n_total++; if (h_index[s0 + 5] !== 5'd1 || h_index[s0 + 6] !== 5'd1 || h_index[s0 + 3] !== 5'd0)
            $display("FAIL rst_line0: got %0d,%0d,%0d expected 0,1,1", h_index[s0 + 3], h_index[s0 + 5], h_index[s0 + 6]); else n_pass++;
        n_total++; if (h_index[s0 + 13] !== 5'd5) $display("FAIL rst_hl_cleared: got %0d expected 5", h_index[s0 + 13]); else n_pass++;
        n_total++; if (h_addr[s1] !== 17'd0 || h_addr[s2] !== 17'd320)
            $display("FAIL rst_bases: got %0d,%0d expected 0,320", h_addr[s1], h_addr[s2]); else n_pass++;
    endtask

    task automatic test_simultaneous();
        int c0, c1, c2;
        vsync();
        repeat (640) tick(1'b1, 1'b1, 1'b1);
        repeat (6) tick(1'b0, 1'b1, 1'b0);
        repeat (4) tick(1'b0, 1'b1, 1'b1);
        do_line(640, c0);
        do_line(640, c1);
        do_line(640, c2);
        n_total++; if (h_addr[c0] !== 17'd0 || h_index[c0 + 5] !== 5'd1)
            $display("FAIL sim_line0: got addr=%0d idx=%0d expected 0/1", h_addr[c0], h_index[c0 + 5]); else n_pass++;
        n_total++; if (h_addr[c1] !== 17'd0 || h_index[c1 + 7] !== 5'd2)
            $display("FAIL sim_line1: got addr=%0d idx=%0d expected 0/2", h_addr[c1], h_index[c1 + 7]); else n_pass++;
        n_total++; if (h_addr[c2] !== 17'd320) $display("FAIL sim_line2: got %0d expected 320", h_addr[c2]); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_latency();
        test_overscan();
        test_highlight();
        test_reset_midline();
        test_simultaneous();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
